// File: rtl/rv32i_sc_core.sv
// Single-cycle RV32I core: PC, instruction ROM, register file, ALU, branch unit and data RAM.
// Optional retirement trace is compiled in when RV_TRACE_EN is defined.

module rv32i_imem #(
    parameter int    DEPTH_WORDS = 2048,
    parameter string IMEM_INIT   = ""
) (
    input  logic [31:0] addr,
    output logic [31:0] instr
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [0:DEPTH_WORDS-1];
    logic        unused_addr;

    // ROM image: zero-filled at time 0
    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = 32'h0;
    end

    assign instr       = mem[addr[AW+1:2]];
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
endmodule

module rv32i_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);
    logic [31:0] rf [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (we && waddr != 5'd0) begin
            rf[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'h0 : rf[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'h0 : rf[raddr2];
endmodule

module rv32i_dmem #(
    parameter int DMEM_WORDS = 32768
) (
    input  logic        clk,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(DMEM_WORDS);

    logic [31:0]   dataR [0:DMEM_WORDS-1];
    logic [AW-1:0] idx;
    logic          unused_addr;

    // upper address bits are ignored, so the array aliases across the address space
    assign idx         = addr[AW+1:2];
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (be[b]) dataR[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    assign rdata = dataR[idx];
endmodule

module rv32i_sc_core #(
    parameter int    DEPTH_WORDS = 2048,
    parameter string IMEM_INIT   = "",
    parameter int    DMEM_WORDS  = 32768
) (
    input logic clk,
    input logic rst
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc, pc_next, pc_plus4, instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, alu_b, alu_y;
    logic [4:0]  shamt;
    logic        br_taken;
    logic [31:0] mem_addr, mem_rdata, load_data, store_data, wb_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic        load_ok, rf_we;
    logic [3:0]  store_be;

    always_ff @(posedge clk) begin
        if (rst) pc <= 32'h0;
        else     pc <= pc_next;
    end

    rv32i_imem #(.DEPTH_WORDS(DEPTH_WORDS), .IMEM_INIT(IMEM_INIT)) u_imem (
        .addr  (pc),
        .instr (instr)
    );

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign imm_i    = {{20{instr[31]}}, instr[31:20]};
    assign imm_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u    = {instr[31:12], 12'h0};
    assign imm_j    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign pc_plus4 = pc + 32'd4;

    rv32i_regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .we     (rf_we & ~rst),
        .waddr  (rd),
        .wdata  (wb_data)
    );

    assign alu_b = (opcode == OP_REG) ? rs2_val : imm_i;
    assign shamt = alu_b[4:0];

    // instr[30] selects SUB (register form only) and arithmetic right shift
    always_comb begin
        alu_y = 32'h0;
        case (funct3)
            3'b000:  alu_y = (opcode == OP_REG && instr[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_y = rs1_val << shamt;
            3'b010:  alu_y = {31'h0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_y = {31'h0, rs1_val < alu_b};
            3'b100:  alu_y = rs1_val ^ alu_b;
            3'b101:  alu_y = instr[30] ? 32'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'b110:  alu_y = rs1_val | alu_b;
            default: alu_y = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  br_taken = (rs1_val <  rs2_val);
            3'b111:  br_taken = (rs1_val >= rs2_val);
            default: br_taken = 1'b0;
        endcase
    end

    assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);

    rv32i_dmem #(.DMEM_WORDS(DMEM_WORDS)) u_dmem (
        .clk   (clk),
        .addr  (mem_addr),
        .be    (rst ? 4'b0000 : store_be),
        .wdata (store_data),
        .rdata (mem_rdata)
    );

    assign load_byte = 8'(mem_rdata >> {mem_addr[1:0], 3'b000});
    assign load_half = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ok   = 1'b1;
        load_data = mem_rdata;
        case (funct3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b010:  load_data = mem_rdata;
            3'b100:  load_data = {24'h0, load_byte};
            3'b101:  load_data = {16'h0, load_half};
            default: load_ok   = 1'b0;
        endcase
    end

    // anything not decoded below retires as a NOP
    always_comb begin
        rf_we      = 1'b0;
        wb_data    = alu_y;
        pc_next    = pc_plus4;
        store_be   = 4'b0000;
        store_data = rs2_val;
        case (opcode)
            OP_LUI:   begin rf_we = 1'b1; wb_data = imm_u; end
            OP_AUIPC: begin rf_we = 1'b1; wb_data = pc + imm_u; end
            OP_JAL:   begin rf_we = 1'b1; wb_data = pc_plus4; pc_next = pc + imm_j; end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    rf_we   = 1'b1;
                    wb_data = pc_plus4;
                    pc_next = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OP_BRANCH: if (br_taken) pc_next = pc + imm_b;
            OP_LOAD:  begin rf_we = load_ok; wb_data = load_data; end
            OP_STORE: begin
                case (funct3)
                    3'b000: begin store_be = 4'b0001 << mem_addr[1:0]; store_data = {4{rs2_val[7:0]}}; end
                    3'b001: begin store_be = mem_addr[1] ? 4'b1100 : 4'b0011; store_data = {2{rs2_val[15:0]}}; end
                    3'b010: store_be = 4'b1111;
                    default: store_be = 4'b0000;
                endcase
            end
            OP_IMM, OP_REG: rf_we = 1'b1;
            default: rf_we = 1'b0;
        endcase
    end

`ifdef RV_TRACE_EN
    always @(posedge clk) begin
        if (!rst) begin
            if (rf_we && rd != 5'd0)
                $display("PC=%08x INSTR=%08x rd=x%0d wdata=%08x", pc, instr, rd, wb_data);
            if (store_be != 4'b0000)
                $display("ST addr=%08x data=%08x", mem_addr, store_data);
        end
    end
`endif
endmodule

// File: tb/tb_rv32i_sc_core.sv
// Bench for rv32i_sc_core: hand-assembled programs are poked into the ROM, run, and the
// architectural state (PC, rf[], dataR[]) is scored against expectations queued beforehand.

module tb_rv32i_sc_core;
    logic clk = 1'b0;
    logic rst = 1'b1;

    rv32i_sc_core #(.DEPTH_WORDS(2048), .IMEM_INIT(""), .DMEM_WORDS(32768)) dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] prog [$];

    typedef struct {
        int          kind;   // 0 register, 1 data word, 2 pc
        int          idx;
        logic [31:0] val;
    } exp_t;
    exp_t sb [$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          is_imm;
        int          f3;
        int          f7;
        logic [31:0] exp;
    } alu_vec_t;
    alu_vec_t vecs [$];

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        logic [31:0] v;
        v = imm20;
        return {v[19:0], 5'(rd), 7'(op)};
    endfunction

    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
    endfunction

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    function automatic void emit(logic [31:0] w);
        prog.push_back(w);
    endfunction

    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return enc_i(imm, rs1, 0, rd, 'h13);
    endfunction

    // LUI+ADDI pair; the +0x800 compensates for ADDI sign-extending its low 12 bits
    function automatic void li(int rd, logic [31:0] val);
        logic [31:0] hi;
        hi = (val + 32'h800) >> 12;
        emit(enc_u(int'(hi), rd, 'h37));
        emit(addi(rd, rd, int'(val)));
    endfunction

    function automatic void expect_reg(int r, logic [31:0] v);
        sb.push_back('{0, r, v});
    endfunction

    function automatic void expect_mem(int w, logic [31:0] v);
        sb.push_back('{1, w, v});
    endfunction

    function automatic void expect_pc(logic [31:0] v);
        sb.push_back('{2, 0, v});
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_prog();
        for (int i = 0; i < 64; i++)
            dut.u_imem.mem[i] = (i < prog.size()) ? prog[i] : 32'h0;
    endtask

    task automatic restart();
        rst = 1'b1;
        load_prog();
        repeat (5) tick();
        rst = 1'b0;
    endtask

    task automatic check_sb(string tag);
        exp_t        e;
        logic [31:0] act;
        string       nm;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       begin act = dut.u_regfile.rf[e.idx]; nm = $sformatf("%s.x%0d", tag, e.idx); end
                1:       begin act = dut.u_dmem.dataR[e.idx]; nm = $sformatf("%s.dataR[%0d]", tag, e.idx); end
                default: begin act = dut.pc;                  nm = $sformatf("%s.pc", tag); end
            endcase
            n_cmp++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got %08h, expected %08h", nm, act, e.val);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{32'h7fff_ffff, 32'h0000_0001, 1'b0, 0, 'h00, 32'h8000_0000}); // ADD wrap
        vecs.push_back('{32'h0000_0000, 32'h0000_0001, 1'b0, 0, 'h20, 32'hffff_ffff}); // SUB borrow
        vecs.push_back('{32'h0000_0001, 32'h0000_001f, 1'b0, 1, 'h00, 32'h8000_0000}); // SLL 31
        vecs.push_back('{32'h0000_0001, 32'h0000_0021, 1'b0, 1, 'h00, 32'h0000_0002}); // SLL uses low 5 bits
        vecs.push_back('{32'hffff_ffff, 32'h0000_0001, 1'b0, 2, 'h00, 32'h0000_0001}); // SLT signed
        vecs.push_back('{32'hffff_ffff, 32'h0000_0001, 1'b0, 3, 'h00, 32'h0000_0000}); // SLTU unsigned
        vecs.push_back('{32'h0000_0005, 32'h0000_0005, 1'b0, 2, 'h00, 32'h0000_0000}); // SLT equal
        vecs.push_back('{32'hf0f0_f0f0, 32'h0ff0_0ff0, 1'b0, 4, 'h00, 32'hff00_ff00}); // XOR
        vecs.push_back('{32'h8000_0000, 32'h0000_0004, 1'b0, 5, 'h00, 32'h0800_0000}); // SRL
        vecs.push_back('{32'h8000_0000, 32'h0000_0004, 1'b0, 5, 'h20, 32'hf800_0000}); // SRA
        vecs.push_back('{32'h1234_0000, 32'h0000_5678, 1'b0, 6, 'h00, 32'h1234_5678}); // OR
        vecs.push_back('{32'hffff_0000, 32'h1234_5678, 1'b0, 7, 'h00, 32'h1234_0000}); // AND
        vecs.push_back('{32'h0000_0005, 32'hffff_fffa, 1'b1, 0, 'h00, 32'hffff_ffff}); // ADDI -6
        vecs.push_back('{32'hffff_fffe, 32'hffff_ffff, 1'b1, 2, 'h00, 32'h0000_0001}); // SLTI
        vecs.push_back('{32'h0000_0000, 32'hffff_ffff, 1'b1, 3, 'h00, 32'h0000_0001}); // SLTIU sext imm
        vecs.push_back('{32'h0000_ffff, 32'hffff_ffff, 1'b1, 4, 'h00, 32'hffff_0000}); // XORI
        vecs.push_back('{32'h8000_0000, 32'h0000_07ff, 1'b1, 6, 'h00, 32'h8000_07ff}); // ORI
        vecs.push_back('{32'h1234_5678, 32'h0000_00ff, 1'b1, 7, 'h00, 32'h0000_0078}); // ANDI

        @(negedge clk);

        // reset state
        prog.delete();
        emit(enc_j(0, 0));
        restart();
        expect_pc(32'h0);
        for (int r = 1; r < 32; r++) expect_reg(r, 32'h0);
        check_sb("reset");
        tick();
        expect_pc(32'h0);
        check_sb("self_loop");

        // ALU vectors: x1=a, x2=b, x3 = op(x1, x2 or imm)
        foreach (vecs[k]) begin
            prog.delete();
            li(1, vecs[k].a);
            li(2, vecs[k].b);
            if (vecs[k].is_imm) emit(enc_i(int'(vecs[k].b), 1, vecs[k].f3, 3, 'h13));
            else                emit(enc_r(vecs[k].f7, 2, 1, vecs[k].f3, 3));
            emit(enc_j(0, 0));
            expect_reg(3, vecs[k].exp);
            restart();
            repeat (8) tick();
            check_sb($sformatf("alu[%0d]", k));
        end

        // immediate shifts from an all-ones source
        prog.delete();
        emit(addi(1, 0, -1));
        emit(enc_i(28, 1, 5, 2, 'h13));
        emit(enc_i('h404, 1, 5, 3, 'h13));
        emit(enc_r(0, 1, 0, 3, 4));
        emit(enc_j(0, 0));
        expect_reg(2, 32'h0000_000f);
        expect_reg(3, 32'hffff_ffff);
        expect_reg(4, 32'h0000_0001);
        restart();
        repeat (8) tick();
        check_sb("alu_seq");

        // byte/half lanes, sign extension and misaligned accesses
        prog.delete();
        emit(addi(5, 0, 'h100));
        li(6, 32'h8081_8283);
        emit(enc_s(0, 6, 5, 2));
        emit(enc_s(4, 6, 5, 2));
        emit(enc_i(1, 5, 0, 7, 'h03));
        emit(enc_i(1, 5, 4, 8, 'h03));
        emit(enc_i(2, 5, 1, 9, 'h03));
        emit(enc_i(2, 5, 5, 10, 'h03));
        emit(addi(11, 0, 'h55));
        emit(enc_s(3, 11, 5, 0));
        emit(enc_s(5, 11, 5, 1));
        emit(enc_i(3, 5, 1, 12, 'h03));
        emit(enc_i(1, 5, 2, 13, 'h03));
        emit(enc_j(0, 0));
        expect_reg(7, 32'hffff_ff82);
        expect_reg(8, 32'h0000_0082);
        expect_reg(9, 32'hffff_8081);
        expect_reg(10, 32'h0000_8081);
        expect_mem(64, 32'h5581_8283);
        expect_mem(65, 32'h8081_0055);
        expect_reg(12, 32'h0000_5581);
        expect_reg(13, 32'h5581_8283);
        restart();
        repeat (20) tick();
        check_sb("bytehalf");

        // jumps and x0
        prog.delete();
        emit(addi(0, 0, 5));
        emit(addi(2, 0, 7));
        emit(addi(0, 0, 0));
        emit(addi(0, 0, 0));
        emit(enc_j(8, 1));
        emit(enc_j(0, 0));
        emit(enc_i(1, 1, 0, 0, 'h67));
        restart();
        repeat (5) tick();
        expect_reg(1, 32'h0000_0014);
        expect_pc(32'h0000_0018);
        check_sb("jal");
        tick();
        expect_pc(32'h0000_0014);
        check_sb("jalr");
        repeat (4) tick();
        expect_pc(32'h0000_0014);
        expect_reg(0, 32'h0);
        expect_reg(2, 32'h0000_0007);
        check_sb("jump_loop");

        // branches, AUIPC/LUI, and system/unknown opcodes as NOPs
        prog.delete();
        emit(addi(1, 0, -1));
        emit(addi(2, 0, 1));
        emit(enc_b(8, 2, 1, 1)); emit(addi(10, 0, 1));
        emit(enc_b(8, 2, 1, 5)); emit(addi(11, 0, 1));
        emit(enc_b(8, 1, 2, 6)); emit(addi(12, 0, 1));
        emit(enc_b(8, 1, 2, 7)); emit(addi(13, 0, 1));
        emit(enc_b(8, 2, 1, 4)); emit(addi(15, 0, 1));
        emit(enc_b(8, 1, 1, 0)); emit(addi(16, 0, 1));
        emit(enc_b(8, 2, 2, 5)); emit(addi(17, 0, 1));
        emit(enc_u(1, 18, 'h17));
        emit(enc_u('habcde, 19, 'h37));
        emit(32'h0000_0073);
        emit(32'h0000_000f);
        emit(32'hffff_ffff);
        emit(addi(20, 0, 3));
        emit(enc_j(0, 0));
        expect_reg(10, 32'h0);
        expect_reg(11, 32'h1);
        expect_reg(12, 32'h0);
        expect_reg(13, 32'h1);
        expect_reg(15, 32'h0);
        expect_reg(16, 32'h0);
        expect_reg(17, 32'h0);
        expect_reg(18, 32'h0000_1040);
        expect_reg(19, 32'habcd_e000);
        expect_reg(20, 32'h0000_0003);
        expect_reg(31, 32'h0);
        expect_pc(32'h0000_0058);
        restart();
        repeat (30) tick();
        check_sb("branch");

        // store table, BLT sum loop, not-taken BEQ
        prog.delete();
        emit(enc_u('h10, 5, 'h37));
        emit(addi(6, 0, 10));  emit(enc_s(0, 6, 5, 2));
        emit(addi(6, 0, 20));  emit(enc_s(4, 6, 5, 2));
        emit(addi(6, 0, -5));  emit(enc_s(8, 6, 5, 2));
        emit(addi(6, 0, 15));  emit(enc_s(12, 6, 5, 2));
        emit(addi(3, 0, 0));
        emit(addi(8, 0, 0));
        emit(addi(9, 0, 4));
        emit(addi(10, 5, 0));
        emit(enc_i(0, 10, 2, 11, 'h03));
        emit(enc_r(0, 11, 3, 0, 3));
        emit(addi(10, 10, 4));
        emit(addi(8, 8, 1));
        emit(enc_b(-16, 9, 8, 4));
        emit(enc_b(8, 0, 3, 0));
        emit(addi(14, 0, 1));
        emit(enc_j(0, 0));
        for (int pass = 0; pass < 2; pass++) begin
            restart();
            if (pass == 1) begin
                repeat (20) tick();
                rst = 1'b1;
                tick();
                expect_pc(32'h0);
                expect_reg(3, 32'h0);
                expect_reg(5, 32'h0);
                expect_reg(8, 32'h0);
                expect_reg(11, 32'h0);
                check_sb("midreset");
                rst = 1'b0;
            end
            expect_mem(16384, 32'd10);
            expect_mem(16385, 32'd20);
            expect_mem(16386, 32'hffff_fffb);
            expect_mem(16387, 32'd15);
            expect_reg(3, 32'd40);
            expect_reg(8, 32'd4);
            expect_reg(14, 32'd1);
            expect_pc(32'h0000_0050);
            repeat (200) tick();
            check_sb($sformatf("comp%0d", pass));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
